// File: rtl/mux_rr_nto1.sv
// N-to-1 channel multiplexer with a one-deep registered output stage.
// Channel choice is a fixed select index or round-robin from the last granted channel.
module mux_rr_nto1 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W  = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    output logic [WIDTH-1:0]         result,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [SEL_W-1:0]         grant
);

    logic             load_en;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_data;
    logic [SEL_W-1:0] rr_ptr;

    // Output register can take a new item when empty or being drained this cycle.
    assign load_en = !result_valid || result_ready;

    // Channel choice; an out-of-range select matches no channel at all.
    always_comb begin : pick
        int unsigned cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (select == SEL_W'(i) && src_valid[SEL_W'(i)]) begin
                    pick_valid = 1'b1;
                    pick_idx   = SEL_W'(i);
                end
            end
        end else begin
            // Search rr_ptr+1 upward with wrap; rr_ptr itself comes last.
            for (int unsigned k = 1; k <= NUM_SRC; k++) begin
                cand = 32'(rr_ptr) + k;
                if (cand >= NUM_SRC) begin
                    cand = cand - NUM_SRC;
                end
                if (!pick_valid && src_valid[SEL_W'(cand)]) begin
                    pick_valid = 1'b1;
                    pick_idx   = SEL_W'(cand);
                end
            end
        end
    end

    // Data of the chosen channel only; unchosen channels never reach the register.
    always_comb begin : data_mux
        pick_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pick_idx == SEL_W'(i)) begin
                pick_data = src[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : ready_gen
        src_ready = '0;
        if (rst_n && load_en && pick_valid) begin
            src_ready[pick_idx] = 1'b1;
        end
    end

    // Output stage and round-robin pointer; pointer follows every transfer in both modes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            grant        <= '0;
            rr_ptr       <= SEL_W'(NUM_SRC - 1);
        end else if (load_en) begin
            if (pick_valid) begin
                result       <= pick_data;
                grant        <= pick_idx;
                result_valid <= 1'b1;
                rr_ptr       <= pick_idx;
            end else begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Scoreboard bench for mux_rr_nto1: directed stimulus pushes expected items,
// a negedge monitor pops and compares on every downstream transfer.
module tb_mux_rr_nto1;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  gnt;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] src;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic         mode;
    logic [1:0]   select;
    logic [31:0]  result;
    logic         result_valid;
    logic         result_ready;
    logic [1:0]   grant;

    logic [23:0]  src3;
    logic [2:0]   src_valid3;
    logic [2:0]   src_ready3;
    logic         mode3;
    logic [1:0]   select3;
    logic [7:0]   result3;
    logic         result_valid3;
    logic         result_ready3;
    logic [1:0]   grant3;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mux_rr_nto1 #(.WIDTH(32), .NUM_SRC(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src          (src),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .mode         (mode),
        .select       (select),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .grant        (grant)
    );

    mux_rr_nto1 #(.WIDTH(8), .NUM_SRC(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .src          (src3),
        .src_valid    (src_valid3),
        .src_ready    (src_ready3),
        .mode         (mode3),
        .select       (select3),
        .result       (result3),
        .result_valid (result_valid3),
        .result_ready (result_ready3),
        .grant        (grant3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        src[i*32 +: 32] = v;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] g);
        exp_t e;
        e.data = d;
        e.gnt  = g;
        exp_q.push_back(e);
    endtask

    // Monitor: a transfer happens on the coming edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && result_valid === 1'b1 && result_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scb_unexpected: got result 0x%0h grant %0d expected no item", result, grant);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("scb_result", result, e.data);
                check("scb_grant", {30'b0, grant}, {30'b0, e.gnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_rdy [6];
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        rst_n = 1'b0;
        src = '0;
        src_valid = 4'b1111;
        mode = 1'b0;
        select = 2'd0;
        result_ready = 1'b1;
        src3 = '0;
        src_valid3 = '0;
        mode3 = 1'b0;
        select3 = '0;
        result_ready3 = 1'b1;
        set_ch(0, 32'd1);
        set_ch(1, 32'd2);
        set_ch(2, 32'd3);
        set_ch(3, 32'd4);
        step();
        step();

        // Reset state, with all requests valid
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'b0, result_valid}, 32'd0);
        check("rst_grant", {30'b0, grant}, 32'd0);
        check("rst_ready", {28'b0, src_ready}, 32'd0);
        step();
        rst_n = 1'b1;

        // Fixed select stepping 0..3
        push(32'd1, 2'd0);
        push(32'd2, 2'd1);
        push(32'd3, 2'd2);
        push(32'd4, 2'd3);
        for (int s = 0; s < 4; s++) begin
            select = 2'(s);
            @(negedge clk);
            check("fix_ready", {28'b0, src_ready}, 32'd1 << s);
            step();
        end
        src_valid = 4'b0000;
        @(negedge clk);
        step();
        @(negedge clk);
        check("fix_drain_valid", {31'b0, result_valid}, 32'd0);
        check("fix_drain_hold", result, 32'd4);
        step();

        // Round-robin fairness from reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mode = 1'b1;
        src_valid = 4'b1111;
        push(32'd1, 2'd0);
        push(32'd2, 2'd1);
        push(32'd3, 2'd2);
        push(32'd4, 2'd3);
        push(32'd1, 2'd0);
        push(32'd2, 2'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_ready", {28'b0, src_ready}, {28'b0, rr_rdy[k]});
            step();
        end
        src_valid = 4'b0000;
        @(negedge clk);
        step();

        // Backpressure: hold 0xA5 for three cycles
        result_ready = 1'b0;
        set_ch(0, 32'h10);
        set_ch(1, 32'h11);
        set_ch(2, 32'hA5);
        set_ch(3, 32'h13);
        src_valid = 4'b0100;
        push(32'hA5, 2'd2);
        push(32'h13, 2'd3);
        @(negedge clk);
        check("bp_first_ready", {28'b0, src_ready}, 32'b0100);
        step();
        src_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_result", result, 32'hA5);
            check("bp_hold_grant", {30'b0, grant}, 32'd2);
            check("bp_hold_valid", {31'b0, result_valid}, 32'd1);
            check("bp_hold_ready", {28'b0, src_ready}, 32'd0);
            step();
        end
        result_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {28'b0, src_ready}, 32'b1000);
        step();
        src_valid = 4'b0000;
        @(negedge clk);
        step();

        // Sparse request: only channel 2
        src_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            set_ch(2, 32'h20 + 32'(k));
            push(32'h20 + 32'(k), 2'd2);
            @(negedge clk);
            check("sparse_ready", {28'b0, src_ready}, 32'b0100);
            step();
        end
        src_valid = 4'b0000;
        @(negedge clk);
        step();

        // Mode switch: fixed grant moves the round-robin pointer
        set_ch(0, 32'h30);
        set_ch(1, 32'h31);
        set_ch(2, 32'h32);
        set_ch(3, 32'h33);
        mode = 1'b0;
        select = 2'd1;
        src_valid = 4'b1111;
        push(32'h31, 2'd1);
        @(negedge clk);
        check("sw_fix_ready", {28'b0, src_ready}, 32'b0010);
        step();
        mode = 1'b1;
        push(32'h32, 2'd2);
        @(negedge clk);
        check("sw_rr_ready", {28'b0, src_ready}, 32'b0100);
        step();
        src_valid = 4'b0000;
        @(negedge clk);
        step();

        // Reset mid-operation discards the held item
        result_ready = 1'b0;
        src_valid = 4'b1111;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", {31'b0, result_valid}, 32'd1);
        check("mid_rst_ready", {28'b0, src_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_result", result, 32'd0);
        check("mid_valid", {31'b0, result_valid}, 32'd0);
        check("mid_grant", {30'b0, grant}, 32'd0);
        check("mid_next_ready", {28'b0, src_ready}, 32'b0001);
        push(32'h30, 2'd0);
        step();
        result_ready = 1'b1;
        src_valid = 4'b0000;
        @(negedge clk);
        step();

        // Three-channel instance: out-of-range select
        src3 = {8'h33, 8'h22, 8'h11};
        src_valid3 = 3'b111;
        mode3 = 1'b0;
        select3 = 2'd1;
        @(negedge clk);
        check("n3_sel1_ready", {29'b0, src_ready3}, 32'b010);
        step();
        select3 = 2'd3;
        @(negedge clk);
        check("n3_result", {24'b0, result3}, 32'h22);
        check("n3_grant", {30'b0, grant3}, 32'd1);
        check("n3_oor_ready", {29'b0, src_ready3}, 32'd0);
        step();
        @(negedge clk);
        check("n3_oor_valid", {31'b0, result_valid3}, 32'd0);
        check("n3_oor_hold", {24'b0, result3}, 32'h22);
        step();

        check("scb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
